// File: rtl/project5_top_if.sv
// Board I/O bundle for project5_top: push-buttons, switches, seven-segment digits and LEDs.
interface project5_top_if;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [6:0] HEX4;
  logic [6:0] HEX5;
  logic [9:0] LED;

  modport master (
    output KEY, SW,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LED
  );

  modport slave (
    input  KEY, SW,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LED
  );
endinterface

// File: rtl/project5_top.sv
// Board top of a step-driven ALU: opcode, A and B are entered on SW one KEY[0] press at a time,
// and the 16-bit result is shown in hex on HEX3..HEX0.
module project5_top #(
  parameter logic [15:0] ID_CONST = 16'h4813
) (
  input logic            CLOCK_50,
  project5_top_if.slave  io
);

  localparam logic [1:0] StOpcode = 2'd0;
  localparam logic [1:0] StLoadA  = 2'd1;
  localparam logic [1:0] StLoadB  = 2'd2;
  localparam logic [1:0] StResult = 2'd3;

  logic        rst_n;
  logic        unused_inputs;
  logic        key_meta_q, key_sync_q, key_prev_q;
  logic        step;
  logic [1:0]  state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  alu_a, alu_b;
  logic [15:0] alu_res;
  logic [15:0] disp;
  logic        unary_op;

  assign rst_n         = io.KEY[1];
  assign unused_inputs = ^{io.SW[9:8], io.KEY[3:2]};

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      key_prev_q <= 1'b1;
    end else begin
      key_meta_q <= io.KEY[0];
      key_sync_q <= key_meta_q;
      key_prev_q <= key_sync_q;
    end
  end

  assign step     = key_prev_q & ~key_sync_q;
  assign unary_op = (opcode_q == 4'b0010) || (opcode_q == 4'b0111);

  // Operands come live from SW on the cycle that captures them.
  assign alu_a = (state_q == StLoadA) ? io.SW[7:0] : a_q;
  assign alu_b = (state_q == StLoadB) ? io.SW[7:0] : b_q;

  always_comb begin
    logic signed [15:0] sa, sb;
    logic [15:0]        dbl, dbl_l;
    logic [7:0]         sh8;
    sa      = {{8{alu_a[7]}}, alu_a};
    sb      = {{8{alu_b[7]}}, alu_b};
    dbl     = {alu_a, alu_a} >> alu_b[2:0];
    dbl_l   = {alu_a, alu_a} << alu_b[2:0];
    sh8     = 8'h00;
    alu_res = 16'h0000;
    case (opcode_q)
      4'b0000: alu_res = sa + sb;
      4'b0001: alu_res = sa - sb;
      4'b0010: alu_res = -sa;
      4'b0011: alu_res = sa * sb;
      4'b0100: alu_res = {8'h00, alu_a & alu_b};
      4'b0101: alu_res = {8'h00, alu_a | alu_b};
      4'b0110: alu_res = {8'h00, alu_a ^ alu_b};
      4'b0111: alu_res = {8'h00, ~alu_a};
      4'b1000: alu_res = {8'h00, dbl[7:0]};
      4'b1001: alu_res = {8'h00, dbl_l[15:8]};
      4'b1010: begin
        sh8     = alu_a << alu_b[2:0];
        alu_res = {8'h00, sh8};
      end
      4'b1011: begin
        sh8     = $signed(alu_a) >>> alu_b[2:0];
        alu_res = {8'h00, sh8};
      end
      4'b1100: alu_res = {alu_a, alu_b} & ID_CONST;
      default: alu_res = 16'h0000;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    if (step) begin
      case (state_q)
        StOpcode: begin
          opcode_d = io.SW[3:0];
          state_d  = StLoadA;
        end
        StLoadA: begin
          a_d = io.SW[7:0];
          if (unary_op) begin
            result_d = alu_res;
            state_d  = StResult;
          end else begin
            state_d = StLoadB;
          end
        end
        StLoadB: begin
          b_d      = io.SW[7:0];
          result_d = alu_res;
          state_d  = StResult;
        end
        default: state_d = StOpcode;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StOpcode;
      opcode_q <= 4'h0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    case (state_q)
      StOpcode: disp = {12'h000, io.SW[3:0]};
      StLoadA:  disp = {8'h00, io.SW[7:0]};
      StLoadB:  disp = {8'h00, io.SW[7:0]};
      default:  disp = result_q;
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign io.HEX0 = seg7(disp[3:0]);
  assign io.HEX1 = seg7(disp[7:4]);
  assign io.HEX2 = seg7(disp[11:8]);
  assign io.HEX3 = seg7(disp[15:12]);
  assign io.HEX4 = seg7({2'b00, state_q});
  assign io.HEX5 = seg7(opcode_q);
  assign io.LED  = {2'b00, opcode_q, 4'b0001 << state_q};

endmodule

// File: tb/tb_project5_top.sv
// Directed bench for project5_top: enters each op through the step button and scoreboards the
// displayed result against values worked out by hand.
module tb_project5_top;

  logic clk;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0] exp_q[$];

  project5_top_if io ();

  project5_top dut (
    .CLOCK_50 (clk),
    .io       (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        unary;
    logic [15:0] exp;
    string       tag;
  } op_t;

  function automatic logic [6:0] enc(input logic [3:0] v);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[v];
  endfunction

  function automatic logic [3:0] dec(input logic [6:0] s);
    logic [3:0] r;
    r = 4'hx;
    for (int i = 0; i < 16; i++) if (enc(4'(i)) === s) r = 4'(i);
    return r;
  endfunction

  function automatic logic [15:0] shown();
    return {dec(io.HEX3), dec(io.HEX2), dec(io.HEX1), dec(io.HEX0)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [9:0] sw, input int hold);
    io.SW     = sw;
    io.KEY[0] = 1'b0;
    repeat (hold) @(negedge clk);
    io.KEY[0] = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_op(input op_t t);
    int waited;
    press({6'h0, t.op}, 1);
    press({2'b00, t.a}, 1);
    if (!t.unary) press({2'b00, t.b}, 1);
    exp_q.push_back(t.exp);
    waited = 0;
    while (io.LED[3:0] !== 4'b1000 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check({t.tag, "_state"}, {12'h0, io.LED[3:0]}, 16'h0008);
    check({t.tag, "_opled"}, {12'h0, io.LED[7:4]}, {12'h0, t.op});
    if (exp_q.size() != 0) check({t.tag, "_result"}, shown(), exp_q.pop_front());
    press(10'h000, 1);
    check({t.tag, "_back"}, {12'h0, io.LED[3:0]}, 16'h0001);
  endtask

  op_t ops[$];

  initial begin
    ops = '{
      '{4'b0000, 8'h0A, 8'h05, 1'b0, 16'h000F, "add"},
      '{4'b0001, 8'h07, 8'h0C, 1'b0, 16'hFFFB, "sub"},
      '{4'b0010, 8'h09, 8'h00, 1'b1, 16'hFFF7, "neg"},
      '{4'b0011, 8'h03, 8'h05, 1'b0, 16'h000F, "mult"},
      '{4'b0011, 8'hFE, 8'h05, 1'b0, 16'hFFF6, "mult_neg"},
      '{4'b0100, 8'hAA, 8'h0F, 1'b0, 16'h000A, "and"},
      '{4'b0101, 8'h51, 8'h0F, 1'b0, 16'h005F, "or"},
      '{4'b0110, 8'hAA, 8'h0F, 1'b0, 16'h00A5, "xor"},
      '{4'b0111, 8'h55, 8'h00, 1'b1, 16'h00AA, "not"},
      '{4'b1000, 8'h81, 8'h03, 1'b0, 16'h0030, "ror"},
      '{4'b1001, 8'h81, 8'h02, 1'b0, 16'h0006, "rol"},
      '{4'b1010, 8'hF0, 8'h02, 1'b0, 16'h00C0, "asl"},
      '{4'b1011, 8'hF0, 8'h02, 1'b0, 16'h00FC, "asr"},
      '{4'b1011, 8'h70, 8'h0A, 1'b0, 16'h001C, "asr_b210"},
      '{4'b1100, 8'h48, 8'h13, 1'b0, 16'h4813, "idand"},
      '{4'b1100, 8'hFF, 8'hFF, 1'b0, 16'h4813, "idand_ff"},
      '{4'b1111, 8'h12, 8'h34, 1'b0, 16'h0000, "op_f"}
    };

    io.KEY = 4'b1101;
    io.SW  = 10'h3A5;
    repeat (3) @(negedge clk);
    check("rst_led", {6'h0, io.LED}, 16'h0001);
    check("rst_hex4", {9'h0, io.HEX4}, {9'h0, enc(4'h0)});
    check("rst_hex5", {9'h0, io.HEX5}, {9'h0, enc(4'h0)});
    io.KEY = 4'b1111;
    repeat (3) @(negedge clk);
    check("opcode_disp", shown(), 16'h0005);

    foreach (ops[i]) run_op(ops[i]);

    // A long hold must advance exactly once.
    press(10'h000, 10);
    repeat (6) @(negedge clk);
    check("hold_state", {12'h0, io.LED[3:0]}, 16'h0002);
    check("hold_hex4", {9'h0, io.HEX4}, {9'h0, enc(4'h1)});
    io.SW = 10'h0A5;
    @(negedge clk);
    check("loada_live", shown(), 16'h00A5);

    press(10'h033, 1);
    check("loadb_state", {12'h0, io.LED[3:0]}, 16'h0004);
    io.KEY[1] = 1'b0;
    #2;
    check("midrst_led", {6'h0, io.LED}, 16'h0001);
    @(negedge clk);
    io.KEY[1] = 1'b1;
    io.SW     = 10'h000;
    repeat (3) @(negedge clk);
    check("midrst_hex5", {9'h0, io.HEX5}, {9'h0, enc(4'h0)});
    check("midrst_disp", shown(), 16'h0000);

    // A step caught in the synchronizer when reset hits must be dropped.
    io.KEY[0] = 1'b0;
    @(negedge clk);
    io.KEY[1] = 1'b0;
    io.KEY[0] = 1'b1;
    @(negedge clk);
    io.KEY[1] = 1'b1;
    repeat (6) @(negedge clk);
    check("pending_drop", {12'h0, io.LED[3:0]}, 16'h0001);

    check("sb_empty", 16'(exp_q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/project5_top.md
Name: project5_top

Overview:
- Board-level top of a multi-cycle, FSM-sequenced ALU.
- The user enters an opcode, then operand A, then operand B (if the op needs one) on SW, advancing each step with push-button KEY[0].
- The 16-bit result shows in hex on four seven-segment displays; state and opcode show on the remaining displays and LEDs.
- Single clock domain (CLOCK_50); async active-low reset on KEY[1].

Parameters:
- ID_CONST, 16'h4813, student-ID constant used by the ID-AND opcode.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz, rising edge
- KEY  in  4  push-buttons, active-low. KEY[1] = asynchronous active-low reset. KEY[0] = step. KEY[3:2] unused.
- SW  in  10  SW[3:0] opcode entry; SW[7:0] operand entry; SW[9:8] unused
- HEX5  out  7  opcode register hex digit
- HEX4  out  7  state number hex digit (0..3)
- HEX3..HEX0  out  7 each  display value, hex digits 3..0 (HEX0 = least significant)
- LED  out  10  LED[3:0] one-hot state; LED[7:4] opcode register; LED[9:8] = 0

Behaviour:
- Reset (KEY[1]=0, async):
  - state=OPCODE; opcode, A, B and result registers = 0.
  - Step synchronizer flops = 1 (released).
- Step detection:
  - KEY[0] passes through a 2-flop synchronizer; a one-cycle step pulse fires on the synchronized 1->0 edge.
  - A press held low for one clock must register exactly once; holding the button never repeats.
  - The registered action takes effect within 3 clocks of the press; SW is sampled on the step-pulse cycle.
- FSM states, with encoding and LED[3:0]:
  - OPCODE = 0, 0001
  - LOAD_A = 1, 0010
  - LOAD_B = 2, 0100
  - RESULT = 3, 1000
- Transitions (on step pulse only; otherwise hold):
  - OPCODE: opcode<=SW[3:0]; go to LOAD_A.
  - LOAD_A: A<=SW[7:0]. For unary ops (0010 NEG, 0111 NOT), compute result and go to RESULT; otherwise go to LOAD_B.
  - LOAD_B: B<=SW[7:0]; compute result; go to RESULT.
  - RESULT: go to OPCODE; result register holds its value until the next compute.
- Operations (A, B are 8-bit; result is 16-bit):
  - 0000 ADD: sext(A)+sext(B)
  - 0001 SUB: sext(A)-sext(B)
  - 0010 NEG: -sext(A)
  - 0011 MULT: signed A*B, 16-bit
  - 0100 AND: {8'h00, A&B}
  - 0101 OR: {8'h00, A|B}
  - 0110 XOR: {8'h00, A^B}
  - 0111 NOT: {8'h00, ~A}
  - 1000 ROR: A rotated right by B[2:0], zero-extended
  - 1001 ROL: A rotated left by B[2:0], zero-extended
  - 1010 ASL: A<<B[2:0] (8-bit, zero fill), zero-extended
  - 1011 ASR: A>>>B[2:0] (8-bit, sign fill), zero-extended
  - 1100 ID-AND: {A,B} & ID_CONST
  - 1101..1111: result 16'h0000
- Display value on HEX3..HEX0:
  - OPCODE: {12'h0, SW[3:0]}
  - LOAD_A and LOAD_B: {8'h0, SW[7:0]} (live)
  - RESULT: result register
- Seven-segment encoding: active-low, bit0=a .. bit6=g, full hex 0-F (e.g. 0 = 7'b1000000, F = 7'b0001110).
- Reset mid-sequence: returns immediately to OPCODE with registers cleared; a step pending in the synchronizer is discarded.

Test Plan:
- Reset pulse -> state OPCODE, LED=10'b0000000001, HEX4 shows 0; then ADD op 0, A=10, B=5 -> RESULT, HEX3..0 = 000F, LED[3:0]=1000; one more step -> OPCODE.
- SUB 7-12 -> FFFB; NEG 9 (two steps then RESULT, no B entry) -> FFF7; MULT 3*5 -> 000F.
- Logic: AND AA&0F -> 000A; OR 51|0F -> 005F; XOR AA^0F -> 00A5; NOT 55 -> 00AA (unary path).
- Shifts: ROR 81 by 3 -> 0030; ROL 81 by 2 -> 0006; ASL F0 by 2 -> 00C0; ASR F0 by 2 -> 00FC.
- ID-AND A=48, B=13 -> 4813; opcode 1111 with any operands -> 0000.
- KEY[0] held low for 10 clocks -> exactly one state advance. Assert KEY[1] while in LOAD_B -> OPCODE, result 0000.
